// File: rtl/mem_stream_ctrl.sv
// mem_stream_ctrl: moves words between a stream and a single-port SRAM.
//   Fill  (WRITE): accepts in_valid/in_data beats and writes them to
//                  base_addr, base_addr+1, ... (address wraps modulo 2^ADDR_LEN).
//   Drain (READ) : reads num_words words starting at base_addr and presents them
//                  on out_valid/out_data through a 2-entry output FIFO.
//
// Ports
//   clk, resetn             clock, synchronous active-low reset
//   start_wr, start_rd      operation requests, sampled only in IDLE
//   base_addr, num_words    first address and length, latched at start
//   in_valid/in_data/in_ready      fill stream
//   out_valid/out_data/out_ready   drain stream
//   CEN, WEN, A, D          SRAM chip enable (low), write enable (low), address, write data
//   Q                       SRAM read data, valid the cycle after a read edge
//   busy, done              operation active, one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start_wr / start_rd
// WRITE | filling memory from the input stream
// READ  | draining memory to the output stream
// DONE  | one-cycle done pulse, then back to IDLE
module mem_stream_ctrl #(
  parameter int WORD_LEN = 32,
  parameter int ADDR_LEN = 10
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start_wr,
  input  logic                start_rd,
  input  logic [ADDR_LEN-1:0] base_addr,
  input  logic [ADDR_LEN:0]   num_words,
  input  logic                in_valid,
  input  logic [WORD_LEN-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [WORD_LEN-1:0] out_data,
  input  logic                out_ready,
  output logic                CEN,
  output logic                WEN,
  output logic [ADDR_LEN-1:0] A,
  output logic [WORD_LEN-1:0] D,
  input  logic [WORD_LEN-1:0] Q,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  localparam logic [ADDR_LEN:0] CNT_ONE = {{ADDR_LEN{1'b0}}, 1'b1};

  state_t              state, state_nxt;
  logic [ADDR_LEN-1:0] base_q;
  logic [ADDR_LEN:0]   num_q;
  logic [ADDR_LEN:0]   wr_cnt;
  logic [ADDR_LEN:0]   rd_issue_cnt;
  logic [ADDR_LEN:0]   rd_acc_cnt;
  logic                rd_inflight;
  logic [WORD_LEN-1:0] fifo_mem [2];
  logic                fifo_wr_ptr;
  logic                fifo_rd_ptr;
  logic [1:0]          fifo_cnt;
  logic [1:0]          occ_after;
  logic [ADDR_LEN-1:0] a_hold;
  logic [WORD_LEN-1:0] d_hold;
  logic                wr_beat;
  logic                rd_issue;
  logic                pop;
  logic                push;

  // Q is only meaningful the cycle after a read we issued; a return that lands
  // just after reset is dropped because rd_inflight was cleared.
  assign push     = rd_inflight;
  assign out_data = fifo_mem[fifo_rd_ptr];

  // FIFO occupancy this cycle counting the word in flight, minus the word
  // leaving now. Counting the pop keeps one read per cycle when out_ready is
  // held high; a read is still never issued while the FIFO is full.
  assign occ_after = fifo_cnt + {1'b0, rd_inflight} - {1'b0, pop};

  always_comb begin
    state_nxt = state;
    CEN       = 1'b1;
    WEN       = 1'b1;
    A         = a_hold;
    D         = d_hold;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    wr_beat   = 1'b0;
    rd_issue  = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_wr) begin
          state_nxt = (num_words == '0) ? DONE : WRITE;
        end else if (start_rd) begin
          state_nxt = (num_words == '0) ? DONE : READ;
        end
      end
      WRITE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_beat = 1'b1;
          CEN     = 1'b0;
          WEN     = 1'b0;
          A       = base_q + wr_cnt[ADDR_LEN-1:0];
          D       = in_data;
          if (wr_cnt + CNT_ONE == num_q) begin
            state_nxt = DONE;
          end
        end
      end
      READ: begin
        out_valid = (fifo_cnt != 2'd0);
        pop       = out_valid && out_ready;
        if ((rd_issue_cnt != num_q) && (fifo_cnt != 2'd2) && (occ_after < 2'd2)) begin
          rd_issue = 1'b1;
          CEN      = 1'b0;
          A        = base_q + rd_issue_cnt[ADDR_LEN-1:0];
        end
        if (pop && (rd_acc_cnt + CNT_ONE == num_q)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      base_q       <= '0;
      num_q        <= '0;
      wr_cnt       <= '0;
      rd_issue_cnt <= '0;
      rd_acc_cnt   <= '0;
      rd_inflight  <= 1'b0;
      fifo_mem[0]  <= '0;
      fifo_mem[1]  <= '0;
      fifo_wr_ptr  <= 1'b0;
      fifo_rd_ptr  <= 1'b0;
      fifo_cnt     <= 2'd0;
      a_hold       <= '0;
      d_hold       <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        wr_cnt       <= '0;
        rd_issue_cnt <= '0;
        rd_acc_cnt   <= '0;
        if (start_wr || start_rd) begin
          base_q <= base_addr;
          num_q  <= num_words;
        end
      end else begin
        if (wr_beat)  wr_cnt       <= wr_cnt + CNT_ONE;
        if (rd_issue) rd_issue_cnt <= rd_issue_cnt + CNT_ONE;
        if (pop)      rd_acc_cnt   <= rd_acc_cnt + CNT_ONE;
      end
      if (!CEN) begin
        a_hold <= A;
        d_hold <= D;
      end
      rd_inflight <= rd_issue;
      if (push) begin
        fifo_mem[fifo_wr_ptr] <= Q;
        fifo_wr_ptr           <= ~fifo_wr_ptr;
      end
      if (pop) begin
        fifo_rd_ptr <= ~fifo_rd_ptr;
      end
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_mem_stream_ctrl.sv
module tb_mem_stream_ctrl;
  localparam int WL    = 32;
  localparam int AL    = 10;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start_wr, start_rd;
  logic [AL-1:0] base_addr;
  logic [AL:0]   num_words;
  logic          in_valid;
  logic [WL-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [WL-1:0] out_data;
  logic          out_ready;
  logic          CEN, WEN;
  logic [AL-1:0] A;
  logic [WL-1:0] D;
  logic [WL-1:0] Q;
  logic          busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WL-1:0] sram    [DEPTH];
  logic [WL-1:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  mem_stream_ctrl #(.WORD_LEN(WL), .ADDR_LEN(AL)) dut (
    .clk(clk), .resetn(resetn),
    .start_wr(start_wr), .start_rd(start_rd),
    .base_addr(base_addr), .num_words(num_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .CEN(CEN), .WEN(WEN), .A(A), .D(D), .Q(Q),
    .busy(busy), .done(done)
  );

  // single-port synchronous SRAM
  always @(posedge clk) begin
    if (!CEN) begin
      if (!WEN) sram[A] <= D;
      else      Q       <= sram[A];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_fill(input int base, input int n, input int pct, input bit idx_data, input bit both);
    int beats = 0;
    int cyc = 0;
    int budget = 20 * n + 50;
    @(posedge clk); #1;
    start_wr  = 1'b1;
    start_rd  = both;
    base_addr = base[AL-1:0];
    num_words = n[AL:0];
    @(negedge clk);
    check_eq("fill_idle_cen", CEN, 1'b1);
    check_eq("fill_idle_busy", busy, 1'b0);
    @(posedge clk); #1;
    start_wr = 1'b0;
    while (beats < n && cyc < budget) begin
      start_rd = 1'($urandom_range(1));
      in_valid = ($urandom_range(99) < pct);
      in_data  = idx_data ? WL'(beats) : $urandom;
      @(negedge clk);
      check_eq("fill_busy", busy, 1'b1);
      check_eq("fill_in_ready", in_ready, 1'b1);
      check_eq("fill_done_early", done, 1'b0);
      if (in_valid) begin
        check_eq("fill_cen", CEN, 1'b0);
        check_eq("fill_wen", WEN, 1'b0);
        check_eq("fill_addr", A, (base + beats) % DEPTH);
        check_eq("fill_data", D, in_data);
        ref_mem[(base + beats) % DEPTH] = in_data;
        beats++;
      end else begin
        check_eq("fill_gap_cen", CEN, 1'b1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    start_rd = 1'b0;
    check_eq("fill_beats", beats, n);
    @(negedge clk);
    check_eq("fill_done", done, 1'b1);
    check_eq("fill_done_cen", CEN, 1'b1);
    check_eq("fill_done_busy", busy, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("fill_after_done", done, 1'b0);
    check_eq("fill_after_busy", busy, 1'b0);
  endtask

  // mode 0: out_ready held 1; mode 1: out_ready 1,0,0,1 repeating; mode 2: random
  // rst_beat > 0: assert reset during that beat and abandon the drain
  task automatic do_drain(input int base, input int n, input int mode, input int rst_beat);
    int beats = 0;
    int cyc = 0;
    int iss_m1 = 0;
    int iss_m2 = 0;
    int occ;
    int budget = 8 * n + 50;
    bit aborted = 1'b0;
    int cur_iss;
    @(posedge clk); #1;
    start_rd  = 1'b1;
    base_addr = base[AL-1:0];
    num_words = n[AL:0];
    @(negedge clk);
    check_eq("drain_idle_cen", CEN, 1'b1);
    @(posedge clk); #1;
    start_rd = 1'b0;
    while (beats < n && cyc < budget) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = 1'($urandom_range(1));
      endcase
      start_wr = 1'($urandom_range(1));
      @(negedge clk);
      // words returned to the FIFO are those issued two or more cycles ago
      occ = iss_m2 - beats;
      check_eq("rd_ovalid", out_valid, occ > 0);
      check_eq("rd_done_early", done, 1'b0);
      check_eq("rd_in_ready", in_ready, 1'b0);
      if (cyc == 2) check_eq("rd_first_ovalid", out_valid, 1'b1);
      if (mode == 0 && cyc >= 2) check_eq("rd_stream_ovalid", out_valid, 1'b1);
      if (occ == 2) check_eq("rd_full_cen", CEN, 1'b1);
      cur_iss = CEN ? 0 : 1;
      if (!CEN) begin
        check_eq("rd_wen", WEN, 1'b1);
        check_eq("rd_addr", A, (base + iss_m1) % DEPTH);
        check_eq("rd_overrun", iss_m1 < n, 1'b1);
      end
      if (out_valid && out_ready) begin
        check_eq("rd_data", out_data, ref_mem[(base + beats) % DEPTH]);
        beats++;
        if (beats == rst_beat) begin
          resetn  = 1'b0;
          aborted = 1'b1;
        end
      end
      @(posedge clk); #1;
      iss_m2 = iss_m1;
      iss_m1 += cur_iss;
      cyc++;
      if (aborted) break;
    end
    start_wr  = 1'b0;
    out_ready = 1'b0;
    if (aborted) begin
      resetn = 1'b1;
      @(negedge clk);
      check_eq("rst_ovalid", out_valid, 1'b0);
      check_eq("rst_cen", CEN, 1'b1);
      check_eq("rst_wen", WEN, 1'b1);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_addr", A, 0);
      check_eq("rst_d", D, 0);
    end else begin
      check_eq("rd_beats", beats, n);
      @(negedge clk);
      check_eq("rd_done", done, 1'b1);
      check_eq("rd_done_cen", CEN, 1'b1);
      check_eq("rd_issued_total", iss_m1, n);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("rd_after_done", done, 1'b0);
      check_eq("rd_after_busy", busy, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
    resetn    = 1'b0;
    start_wr  = 1'b0;
    start_rd  = 1'b0;
    base_addr = '0;
    num_words = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_cen", CEN, 1'b1);
    check_eq("reset_wen", WEN, 1'b1);
    check_eq("reset_addr", A, 0);
    check_eq("reset_d", D, 0);
    check_eq("reset_in_ready", in_ready, 1'b0);
    check_eq("reset_ovalid", out_valid, 1'b0);
    check_eq("reset_done", done, 1'b0);
    check_eq("reset_busy", busy, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;

    do_fill(0, 1024, 100, 1'b1, 1'b0);
    do_drain(0, 1024, 0, 0);

    do_fill(1022, 4, 70, 1'b0, 1'b0);
    do_drain(1022, 4, 2, 0);

    do_fill(1020, 8, 60, 1'b0, 1'b0);
    do_drain(1020, 8, 1, 0);

    do_fill(300, 0, 100, 1'b0, 1'b0);
    do_drain(300, 0, 0, 0);

    do_fill(100, 5, 60, 1'b0, 1'b1);
    do_drain(100, 5, 0, 0);

    do_fill(500, 12, 80, 1'b0, 1'b0);
    do_drain(500, 12, 0, 5);
    do_drain(500, 12, 0, 0);

    for (int k = 0; k < 6; k++) begin
      int b;
      int n;
      b = $urandom_range(DEPTH - 1);
      n = $urandom_range(40, 1);
      do_fill(b, n, 70, 1'b0, 1'b0);
      do_drain(b, n, 2, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
